// File: rtl/mem_write_checker.sv
// Data-memory write-port checker: compares monitored writes in program order against a
// runtime-loaded expected list, skipping ignore-listed addresses, with an optional timeout.
module mem_write_checker #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_EXP = 4,
  parameter int unsigned NUM_IGN = 2,
  parameter int unsigned TO_W    = 16,
  localparam int unsigned CW  = $clog2(NUM_EXP + 1),
  localparam int unsigned IW  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int unsigned IGW = (NUM_IGN > 1) ? $clog2(NUM_IGN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     exp_len,
  input  logic [TO_W-1:0]   timeout_lim,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_adr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_ign_en,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CW-1:0]     match_cnt,
  output logic [7:0]        ign_cnt,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StPass = 2'd2;
  localparam logic [1:0] StFail = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] exp_adr_q  [NUM_EXP];
  logic [DATA_W-1:0] exp_data_q [NUM_EXP];
  logic [ADDR_W-1:0] ign_adr_q  [NUM_IGN];
  logic [NUM_IGN-1:0] ign_en_q;
  logic [CW-1:0]     len_q, match_q, match_d;
  logic [TO_W-1:0]   lim_q, timer_q, timer_d;
  logic [7:0]        ign_q, ign_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] fadr_q, fadr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [IW-1:0]  ptr;
  logic [IGW-1:0] ign_idx;
  logic [31:0]    exp_idx_ext, ign_idx_ext;
  logic           adr_hit, data_hit, ign_hit, cfg_ok;

  // match_cnt doubles as the read pointer into the expected list
  assign ptr         = match_q[IW-1:0];
  assign ign_idx     = cfg_idx[IGW-1:0];
  assign exp_idx_ext = 32'(cfg_idx);
  assign ign_idx_ext = 32'(ign_idx);
  assign cfg_ok      = cfg_we && (state_q != StRun);
  assign adr_hit     = (DataAdr == exp_adr_q[ptr]);
  assign data_hit    = (WriteData == exp_data_q[ptr]);

  always_comb begin
    ign_hit = 1'b0;
    for (int i = 0; i < int'(NUM_IGN); i++) begin
      if (ign_en_q[i] && (ign_adr_q[i] == DataAdr)) ign_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    ign_d   = ign_q;
    code_d  = code_q;
    fadr_d  = fadr_q;
    fdata_d = fdata_q;
    timer_d = timer_q;
    if (start) begin
      state_d = (exp_len == '0) ? StPass : StRun;
      match_d = '0;
      ign_d   = '0;
      code_d  = 2'd0;
      fadr_d  = '0;
      fdata_d = '0;
      timer_d = '0;
    end else if (state_q == StRun) begin
      timer_d = timer_q + TO_W'(1);
      if (MemWrite) begin
        if (adr_hit && data_hit) begin
          match_d = match_q + CW'(1);
          if (match_d == len_q) state_d = StPass;
        end else if (ign_hit) begin
          if (ign_q != 8'hff) ign_d = ign_q + 8'd1;
        end else begin
          state_d = StFail;
          code_d  = adr_hit ? 2'd2 : 2'd1;
          fadr_d  = DataAdr;
          fdata_d = WriteData;
        end
      end
      // A write resolved on this edge takes precedence over the timeout
      if ((state_d == StRun) && (lim_q != '0) && (timer_d == lim_q)) begin
        state_d = StFail;
        code_d  = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      lim_q   <= '0;
      match_q <= '0;
      ign_q   <= '0;
      code_q  <= '0;
      fadr_q  <= '0;
      fdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      ign_q   <= ign_d;
      code_q  <= code_d;
      fadr_q  <= fadr_d;
      fdata_q <= fdata_d;
      timer_q <= timer_d;
      if (start) begin
        len_q <= exp_len;
        lim_q <= timeout_lim;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_EXP); i++) begin
        exp_adr_q[i]  <= '0;
        exp_data_q[i] <= '0;
      end
      for (int i = 0; i < int'(NUM_IGN); i++) ign_adr_q[i] <= '0;
      ign_en_q <= '0;
    end else if (cfg_ok) begin
      if (!cfg_sel) begin
        if (exp_idx_ext < NUM_EXP) begin
          exp_adr_q[cfg_idx]  <= cfg_adr;
          exp_data_q[cfg_idx] <= cfg_data;
        end
      end else if (ign_idx_ext < NUM_IGN) begin
        ign_adr_q[ign_idx] <= cfg_adr;
        ign_en_q[ign_idx]  <= cfg_ign_en;
      end
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StPass) || (state_q == StFail);
  assign pass      = (state_q == StPass);
  assign fail_code = code_q;
  assign match_cnt = match_q;
  assign ign_cnt   = ign_q;
  assign fail_adr  = fadr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus random traffic scored against a
// queue-based model of the expected write sequence.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  exp_len;
  logic [15:0] timeout_lim;
  logic        cfg_we, cfg_sel, cfg_ign_en;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_adr, cfg_data;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_cnt;
  logic [7:0]  ign_cnt;
  logic [31:0] fail_adr, fail_data;

  always #5 clk = ~clk;

  mem_write_checker dut (
    .clk(clk), .reset(reset), .start(start), .exp_len(exp_len), .timeout_lim(timeout_lim),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .cfg_ign_en(cfg_ign_en), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_cnt(match_cnt), .ign_cnt(ign_cnt), .fail_adr(fail_adr), .fail_data(fail_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: status 0 idle, 1 running, 2 passed, 3 failed
  bit [31:0] m_ea[4], m_ed[4], m_ia[2];
  bit        m_ie[2];
  bit [63:0] m_q[$];
  int        m_st, m_match, m_ign, m_code;
  bit [31:0] m_fa, m_fd;
  longint    m_cyc, m_dead;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin m_ea[i] = 0; m_ed[i] = 0; end
    for (int i = 0; i < 2; i++) begin m_ia[i] = 0; m_ie[i] = 0; end
    m_q.delete();
    m_st = 0; m_match = 0; m_ign = 0; m_code = 0; m_fa = 0; m_fd = 0;
    m_cyc = 0; m_dead = -1;
  endfunction

  function automatic void model_edge();
    int  old;
    bit  ihit;
    old = m_st;
    m_cyc++;
    if (cfg_we && old != 1) begin
      if (!cfg_sel) begin m_ea[cfg_idx] = cfg_adr; m_ed[cfg_idx] = cfg_data; end
      else begin m_ia[cfg_idx[0]] = cfg_adr; m_ie[cfg_idx[0]] = cfg_ign_en; end
    end
    if (start) begin
      m_q.delete();
      for (int i = 0; i < int'(exp_len); i++) m_q.push_back({m_ea[i], m_ed[i]});
      m_match = 0; m_ign = 0; m_code = 0; m_fa = 0; m_fd = 0;
      m_dead = (timeout_lim == 0) ? -1 : m_cyc + longint'(timeout_lim);
      m_st = (exp_len == 0) ? 2 : 1;
    end else if (old == 1) begin
      if (MemWrite) begin
        ihit = 0;
        for (int i = 0; i < 2; i++) if (m_ie[i] && m_ia[i] == DataAdr) ihit = 1;
        if ({DataAdr, WriteData} == m_q[0]) begin
          void'(m_q.pop_front());
          m_match++;
          if (m_q.size() == 0) m_st = 2;
        end else if (ihit) begin
          if (m_ign < 255) m_ign++;
        end else begin
          m_st = 3;
          m_code = (DataAdr == m_q[0][63:32]) ? 2 : 1;
          m_fa = DataAdr; m_fd = WriteData;
        end
      end
      if (m_st == 1 && m_cyc == m_dead) begin m_st = 3; m_code = 3; end
    end
  endfunction

  task automatic check_all();
    check("busy", busy, m_st == 1);
    check("done", done, m_st >= 2);
    check("pass", pass, m_st == 2);
    check("fail_code", fail_code, m_code);
    check("match_cnt", match_cnt, m_match);
    check("ign_cnt", ign_cnt, m_ign);
    check("fail_adr", fail_adr, m_fa);
    check("fail_data", fail_data, m_fd);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    start = 0; cfg_we = 0; MemWrite = 0;
  endtask

  task automatic cfg_exp(input int idx, input int a, input int d);
    cfg_we = 1; cfg_sel = 0; cfg_idx = 2'(idx); cfg_adr = a; cfg_data = d; step();
  endtask

  task automatic cfg_ign(input int idx, input int a, input bit en);
    cfg_we = 1; cfg_sel = 1; cfg_idx = 2'(idx); cfg_adr = a; cfg_ign_en = en; step();
  endtask

  task automatic do_start(input int len, input int lim);
    start = 1; exp_len = 3'(len); timeout_lim = 16'(lim); step();
  endtask

  task automatic bus(input int a, input int d);
    MemWrite = 1; DataAdr = a; WriteData = d; step();
  endtask

  initial begin
    int n;
    reset = 0; start = 0; exp_len = 0; timeout_lim = 0; cfg_we = 0; cfg_sel = 0;
    cfg_idx = 0; cfg_adr = 0; cfg_data = 0; cfg_ign_en = 0; MemWrite = 0;
    DataAdr = 0; WriteData = 0;
    m_reset();
    #22;
    check_all();
    @(negedge clk) reset = 1;

    // Ignored writes then the single expected write
    cfg_exp(0, 100, 7);
    cfg_ign(0, 96, 1);
    do_start(1, 0);
    bus(96, 3); bus(96, 9); bus(100, 7);
    check("tp1_ign", ign_cnt, 2);
    check("tp1_pass", pass, 1);

    do_start(1, 0);
    bus(100, 6);
    check("tp2_code", fail_code, 2);
    check("tp2_adr", fail_adr, 100);
    check("tp2_data", fail_data, 6);

    do_start(1, 0);
    bus(104, 7);
    check("tp3_code", fail_code, 1);
    check("tp3_adr", fail_adr, 104);

    // Timeout lands exactly timeout_lim edges after start
    cfg_exp(1, 104, 8);
    do_start(2, 20);
    bus(100, 7);
    n = 1;
    while (!done && n < 40) begin step(); n++; end
    check("tp4_to_cycles", n, 20);
    check("tp4_code", fail_code, 3);
    check("tp4_match", match_cnt, 1);

    // Final write on the same edge as the timeout: pass wins
    do_start(2, 5);
    step(); step(); step();
    bus(100, 7); bus(104, 8);
    check("tp5_pass", pass, 1);
    check("tp5_code", fail_code, 0);

    // Asynchronous reset mid-run
    do_start(2, 0);
    bus(100, 7);
    #3 reset = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_match", match_cnt, 0);
    m_reset();
    check_all();
    @(negedge clk) reset = 1;
    do_start(0, 0);
    check("tp6_pass", pass, 1);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      start       = ($urandom_range(0, 15) == 0);
      exp_len     = 3'($urandom_range(0, 4));
      timeout_lim = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(2, 20));
      cfg_we      = ($urandom_range(0, 4) == 0);
      cfg_sel     = 1'($urandom_range(0, 1));
      cfg_idx     = 2'($urandom_range(0, 3));
      cfg_adr     = 96 + 4 * $urandom_range(0, 3);
      cfg_data    = $urandom_range(5, 8);
      cfg_ign_en  = 1'($urandom_range(0, 1));
      MemWrite    = 1'($urandom_range(0, 1));
      if (m_st == 1 && m_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        {DataAdr, WriteData} = m_q[0];
      end else begin
        DataAdr   = 96 + 4 * $urandom_range(0, 3);
        WriteData = $urandom_range(5, 8);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
